// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// FSM state encoding and the result payload produced by md_core.
package md_sched_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] multu_a = 4'd0;
    localparam logic [OP_W-1:0] mult_a  = 4'd1;
    localparam logic [OP_W-1:0] divu_a  = 4'd2;
    localparam logic [OP_W-1:0] div_a   = 4'd3;
    localparam logic [OP_W-1:0] mthi_a  = 4'd4;
    localparam logic [OP_W-1:0] mtlo_a  = 4'd5;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              div0;
    } md_res_t;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic is_muldiv(input logic [OP_W-1:0] c);
        return (c == multu_a) || (c == mult_a) || (c == divu_a) || (c == div_a);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit multiply and 32-bit divide of the E-stage operands.
module md_core
    import md_sched_pkg::*;
(
    input  logic [OP_W-1:0]   md_c,
    input  logic [DATA_W-1:0] md_a,
    input  logic [DATA_W-1:0] md_b,
    output md_res_t           res
);

    logic [2*DATA_W-1:0] sprod;
    logic [2*DATA_W-1:0] uprod;
    logic [DATA_W-1:0]   ua;
    logic [DATA_W-1:0]   ub;
    logic [DATA_W-1:0]   ub_safe;
    logic [DATA_W-1:0]   b_safe;
    logic [DATA_W-1:0]   uq;
    logic [DATA_W-1:0]   ur;
    logic [DATA_W-1:0]   udq;
    logic [DATA_W-1:0]   udr;
    logic                b_zero;

    always_comb begin
        sprod   = {{DATA_W{md_a[DATA_W-1]}}, md_a} * {{DATA_W{md_b[DATA_W-1]}}, md_b};
        uprod   = {{DATA_W{1'b0}}, md_a} * {{DATA_W{1'b0}}, md_b};
        b_zero  = (md_b == '0);
        // Signed divide on magnitudes; a zero divisor is replaced so nothing goes X.
        ua      = md_a[DATA_W-1] ? (~md_a + DATA_W'(1)) : md_a;
        ub      = md_b[DATA_W-1] ? (~md_b + DATA_W'(1)) : md_b;
        ub_safe = b_zero ? DATA_W'(1) : ub;
        b_safe  = b_zero ? DATA_W'(1) : md_b;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        udq     = md_a / b_safe;
        udr     = md_a % b_safe;

        res = '0;
        case (md_c)
            multu_a: begin
                res.hi = uprod[2*DATA_W-1:DATA_W];
                res.lo = uprod[DATA_W-1:0];
            end
            mult_a: begin
                res.hi = sprod[2*DATA_W-1:DATA_W];
                res.lo = sprod[DATA_W-1:0];
            end
            divu_a: begin
                res.hi   = udr;
                res.lo   = udq;
                res.div0 = b_zero;
            end
            div_a: begin
                res.hi   = md_a[DATA_W-1] ? (~ur + DATA_W'(1)) : ur;
                res.lo   = (md_a[DATA_W-1] ^ md_b[DATA_W-1]) ? (~uq + DATA_W'(1)) : uq;
                res.div0 = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO owner and multi-cycle mult/div sequencer with D-stage stall generation.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        md_s,
    input  logic [3:0]  md_c,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        m_md,
    input  logic        d_md_use,
    output logic [31:0] hilo,
    output logic        busy,
    output logic        stall
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    md_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    md_res_t           pend, pend_nxt;
    md_res_t           core_res;
    logic [DATA_W-1:0] hi, hi_nxt;
    logic [DATA_W-1:0] lo, lo_nxt;

    md_core u_core (
        .md_c (md_c),
        .md_a (md_a),
        .md_b (md_b),
        .res  (core_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            pend  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        hi_nxt    = hi;
        lo_nxt    = lo;

        case (state)
            MD_IDLE: begin
                if (md_s) begin
                    case (md_c)
                        multu_a, mult_a: begin
                            pend_nxt  = core_res;
                            cnt_nxt   = CNT_W'(MULT_LAT);
                            state_nxt = MD_RUN;
                        end
                        divu_a, div_a: begin
                            pend_nxt  = core_res;
                            cnt_nxt   = CNT_W'(DIV_LAT);
                            state_nxt = MD_RUN;
                        end
                        mthi_a:  hi_nxt = md_a;
                        mtlo_a:  lo_nxt = md_a;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
                // Commit on the 1->0 step; a divide by zero leaves HI/LO alone.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = MD_IDLE;
                    if (!pend.div0) begin
                        hi_nxt = pend.hi;
                        lo_nxt = pend.lo;
                    end
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign busy  = (state == MD_RUN);
    assign stall = d_md_use & (busy | (md_s & is_muldiv(md_c)));
    assign hilo  = m_md ? lo : hi;

endmodule
